// File: rtl/si_tag_pkg.sv
// rtl/si_tag_pkg.sv - record layout, field positions and decoded-tag type for the tag unpacker
package si_tag_pkg;

  localparam int REC_W    = 32;
  localparam int OFFSET_W = 24;
  localparam int BASE_W   = 64 - OFFSET_W;

  localparam int TYPE_HI  = 31;
  localparam int TYPE_LO  = 30;
  localparam int CH_HI    = 29;
  localparam int CH_LO    = 25;
  localparam int EDGE_BIT = 24;
  localparam int ROLL_HI  = 29;

  typedef enum logic [1:0] {
    PAD  = 2'b00,
    TAG  = 2'b01,
    ROLL = 2'b10,
    RSVD = 2'b11
  } rec_type_e;

  typedef struct packed {
    logic [63:0] tagtime;
    logic [4:0]  channel;
    logic        rising_edge;
  } tag_t;

endpackage

// File: rtl/si_tag_decode.sv
// rtl/si_tag_decode.sv - combinational decode of one 32-bit record against the current time base
module si_tag_decode
  import si_tag_pkg::*;
(
  input  logic [REC_W-1:0]  rec,
  input  logic [BASE_W-1:0] time_base,
  output rec_type_e         rec_type,
  output tag_t              tag,
  output logic [BASE_W-1:0] roll_inc
);

  assign rec_type        = rec_type_e'(rec[TYPE_HI:TYPE_LO]);
  assign tag.tagtime     = {time_base, rec[OFFSET_W-1:0]};
  assign tag.channel     = rec[CH_HI:CH_LO];
  assign tag.rising_edge = rec[EDGE_BIT];
  // Rollover payload is an unsigned increment, zero-extended into the base width.
  assign roll_inc        = BASE_W'(rec[ROLL_HI:0]);

endmodule

// File: rtl/si_tag_unpacker.sv
// rtl/si_tag_unpacker.sv - unpacks four tag records per stream word, one slot per cycle
module si_tag_unpacker
  import si_tag_pkg::*;
#(
  parameter int SLOTS    = 4,
  parameter int OFFSET_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [32*SLOTS-1:0]   s_axis_tdata,
  output logic                  valid_tag,
  output logic [63:0]           tagtime,
  output logic [4:0]            channel,
  output logic                  rising_edge,
  output logic [31:0]           stat_rollovers,
  output logic [15:0]           stat_reserved
);

  localparam int TB_W  = 64 - OFFSET_W;
  localparam int IDX_W = $clog2(SLOTS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SLOTS - 1);

  typedef enum logic {IDLE, DRAIN} state_e;

  state_e              state;
  logic [IDX_W-1:0]    idx;
  logic [32*SLOTS-1:0] hold;
  logic [TB_W-1:0]     time_base;

  logic [REC_W-1:0]    rec;
  rec_type_e           rec_type;
  tag_t                dec_tag;
  logic [TB_W-1:0]     roll_inc;
  logic                xfer;

  // Ready depends on state alone so upstream never sees a tvalid->tready path.
  assign s_axis_tready = (state == IDLE) || (idx == LAST);
  assign xfer          = s_axis_tvalid && s_axis_tready;
  assign rec           = hold[32*idx +: 32];

  si_tag_decode u_decode (
    .rec       (rec),
    .time_base (time_base),
    .rec_type  (rec_type),
    .tag       (dec_tag),
    .roll_inc  (roll_inc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      hold           <= '0;
      time_base      <= '0;
      valid_tag      <= 1'b0;
      tagtime        <= '0;
      channel        <= '0;
      rising_edge    <= 1'b0;
      stat_rollovers <= '0;
      stat_reserved  <= '0;
    end else begin
      valid_tag <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            hold  <= s_axis_tdata;
            idx   <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          case (rec_type)
            TAG: begin
              valid_tag   <= 1'b1;
              tagtime     <= dec_tag.tagtime;
              channel     <= dec_tag.channel;
              rising_edge <= dec_tag.rising_edge;
            end
            ROLL: begin
              time_base      <= time_base + roll_inc;
              stat_rollovers <= stat_rollovers + 32'd1;
            end
            RSVD: begin
              if (stat_reserved != 16'hFFFF)
                stat_reserved <= stat_reserved + 16'd1;
            end
            default: ;
          endcase
          // Reloading on the last slot keeps a sustained stream bubble-free.
          if (idx == LAST) begin
            if (xfer) begin
              hold <= s_axis_tdata;
              idx  <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_si_tag_unpacker.sv
// tb/tb_si_tag_unpacker.sv - scoreboard bench for si_tag_unpacker
module tb_si_tag_unpacker;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [127:0] s_axis_tdata = '0;
  logic         valid_tag;
  logic [63:0]  tagtime;
  logic [4:0]   channel;
  logic         rising_edge;
  logic [31:0]  stat_rollovers;
  logic [15:0]  stat_reserved;

  si_tag_unpacker dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdata   (s_axis_tdata),
    .valid_tag      (valid_tag),
    .tagtime        (tagtime),
    .channel        (channel),
    .rising_edge    (rising_edge),
    .stat_rollovers (stat_rollovers),
    .stat_reserved  (stat_reserved)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] t;
    logic [4:0]  ch;
    logic        r;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passed = 0;
  logic [39:0] m_base = '0;
  logic [31:0] m_roll = '0;
  logic [15:0] m_rsv  = '0;

  function automatic logic [31:0] tag_rec(input logic [4:0] ch, input logic r, input logic [23:0] off);
    return {2'b01, ch, r, off};
  endfunction

  function automatic logic [31:0] roll_rec(input logic [29:0] n);
    return {2'b10, n};
  endfunction

  // Slot k of a word taking edge p is visible after edge p+1+k.
  task automatic model_word(input logic [127:0] d, input int p);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] r;
      exp_t e;
      r = d[32*k +: 32];
      case (r[31:30])
        2'b01: begin
          e.t = {m_base, r[23:0]}; e.ch = r[29:25]; e.r = r[24]; e.cyc = p + 1 + k;
          q.push_back(e);
        end
        2'b10: begin m_base = m_base + {10'b0, r[29:0]}; m_roll = m_roll + 1; end
        2'b11: if (m_rsv != 16'hFFFF) m_rsv = m_rsv + 1;
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid_tag) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL stray_strobe: cyc=%0d tagtime=%h ch=%0d rise=%0d, expected no strobe", cyc, tagtime, channel, rising_edge);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (tagtime !== e.t || channel !== e.ch || rising_edge !== e.r || cyc !== e.cyc)
          $display("FAIL tag_out: got t=%h ch=%0d r=%0d cyc=%0d, expected t=%h ch=%0d r=%0d cyc=%0d",
                   tagtime, channel, rising_edge, cyc, e.t, e.ch, e.r, e.cyc);
        else
          passed++;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge with tvalid still high.
  task automatic send_word(input logic [127:0] d, output int p);
    int w;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    w = 0;
    p = -1;
    while (!s_axis_tready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!s_axis_tready) begin
      checks++;
      $display("FAIL tready_timeout: tready=%0d after %0d cycles, expected 1", s_axis_tready, w);
    end else begin
      p = cyc + 1;
      model_word(d, p);
      @(negedge clk);
    end
  endtask

  task automatic finish_stream();
    int w;
    s_axis_tvalid = 1'b0;
    w = 0;
    while (q.size() != 0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (q.size() != 0) $display("FAIL drain: %0d tags outstanding, expected 0", q.size());
    else passed++;
  endtask

  task automatic check_stats(input string name);
    checks++;
    if (stat_rollovers !== m_roll || stat_reserved !== m_rsv)
      $display("FAIL %s_stats: rollovers=%0d reserved=%0d, expected %0d %0d", name, stat_rollovers, stat_reserved, m_roll, m_rsv);
    else passed++;
  endtask

  task automatic test_reset();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {4{tag_rec(5'd1, 1'b1, 24'h1)}};
    repeat (3) @(negedge clk);
    checks++;
    if (valid_tag !== 1'b0 || tagtime !== 64'h0 || channel !== 5'h0 || rising_edge !== 1'b0 ||
        stat_rollovers !== 32'h0 || stat_reserved !== 16'h0 || s_axis_tready !== 1'b1)
      $display("FAIL reset_state: vt=%0d t=%h ch=%0d r=%0d sr=%0d sv=%0d rdy=%0d, expected 0s and rdy=1",
               valid_tag, tagtime, channel, rising_edge, stat_rollovers, stat_reserved, s_axis_tready);
    else passed++;
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) $display("FAIL reset_idle: tready=%0d, expected 1", s_axis_tready);
    else passed++;
  endtask

  task automatic test_basic();
    int p;
    send_word({tag_rec(5'd0, 1'b0, 24'hFFFFFF), 32'h0, tag_rec(5'd3, 1'b1, 24'h10), 32'h0}, p);
    finish_stream();
  endtask

  task automatic test_rollover();
    int p;
    send_word({32'h0, 32'h0, tag_rec(5'd9, 1'b1, 24'h5), roll_rec(30'd1)}, p);
    finish_stream();
    checks++;
    if (stat_rollovers !== 32'd1) $display("FAIL rollover_count: got %0d, expected 1", stat_rollovers);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int p[3];
    for (int w = 0; w < 3; w++)
      send_word({tag_rec(5'(4*w+3), 1'b0, 24'(w+40)), tag_rec(5'(4*w+2), 1'b1, 24'(w+30)),
                 tag_rec(5'(4*w+1), 1'b0, 24'(w+20)), tag_rec(5'(4*w), 1'b1, 24'(w+10))}, p[w]);
    finish_stream();
    checks++;
    if (p[1] - p[0] !== 4 || p[2] - p[1] !== 4)
      $display("FAIL b2b_spacing: transfer gaps %0d %0d, expected 4 4", p[1] - p[0], p[2] - p[1]);
    else passed++;
  endtask

  task automatic test_base_wrap();
    int p;
    logic [39:0] adj;
    for (int w = 0; w < 256; w++) send_word({4{roll_rec(30'h3FFFFFFF)}}, p);
    adj = 40'hFFFFFFFFFF - m_base;
    send_word({tag_rec(5'd2, 1'b0, 24'h7), roll_rec(30'd1), tag_rec(5'd31, 1'b1, 24'hAB), roll_rec(adj[29:0])}, p);
    finish_stream();
    check_stats("wrap");
  endtask

  task automatic test_reserved_saturate();
    int p;
    for (int w = 0; w < 16383; w++) send_word({4{32'hC000_0000}}, p);
    finish_stream();
    check_stats("rsvd_pre");
    for (int w = 0; w < 1117; w++) send_word({4{32'hC000_0000}}, p);
    finish_stream();
    checks++;
    if (stat_reserved !== 16'hFFFF) $display("FAIL rsvd_sat: got %h, expected ffff", stat_reserved);
    else passed++;
  endtask

  task automatic test_reset_mid_drain();
    int p;
    send_word({roll_rec(30'd5), 32'h0, 32'h0, 32'h0}, p);
    finish_stream();
    send_word({tag_rec(5'd4, 1'b1, 24'h4), tag_rec(5'd3, 1'b0, 24'h3),
               tag_rec(5'd2, 1'b1, 24'h2), tag_rec(5'd1, 1'b0, 24'h1)}, p);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid_tag !== 1'b0 || tagtime !== 64'h0 || channel !== 5'h0 || rising_edge !== 1'b0 ||
        stat_rollovers !== 32'h0 || stat_reserved !== 16'h0)
      $display("FAIL async_reset: vt=%0d t=%h ch=%0d r=%0d sr=%0d sv=%0d, expected all 0",
               valid_tag, tagtime, channel, rising_edge, stat_rollovers, stat_reserved);
    else passed++;
    q.delete();
    m_base = '0; m_roll = '0; m_rsv = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_word({32'h0, 32'h0, 32'h0, tag_rec(5'd6, 1'b1, 24'h3)}, p);
    finish_stream();
    check_stats("post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rollover();
    test_back_to_back();
    test_base_wrap();
    test_reserved_saturate();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/si_tag_unpacker.md
SI_TAG_UNPACKER -- requirements
Module: si_tag_unpacker

Interface
REQ-001 Parameter SLOTS, default 4, number of 32-bit tag records per input word; fixed at 4 in this revision.
REQ-002 Parameter OFFSET_W, default 24, width of the time-offset field; the time-base width is 64-OFFSET_W (40).
REQ-003 clk  in  1  sole clock; every port is synchronous to it.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 s_axis_tvalid  in  1  input word valid.
REQ-006 s_axis_tready  out  1  block accepts the word this cycle.
REQ-007 s_axis_tdata  in  128  four records; slot k occupies bits [32k+31:32k], and slot 0 is processed first.
REQ-008 valid_tag  out  1  one-cycle strobe, one decoded tag.
REQ-009 tagtime  out  64  tag time in 1/3 ps, equal to {time_base, offset}.
REQ-010 channel  out  5  zero-based channel.
REQ-011 rising_edge  out  1  1 = rising edge, 0 = falling edge.
REQ-012 stat_rollovers  out  32  count of rollover records, wrapping.
REQ-013 stat_reserved  out  16  count of reserved records, saturating at 16'hFFFF.

Function
REQ-014 Record type is bits [31:30]: 00 = padding, 01 = time tag, 10 = rollover, 11 = reserved.
REQ-015 Time-tag record fields: [29:25] channel, [24] rising_edge, [23:0] offset.
REQ-016 Rollover record: time_base <= time_base + {10'b0, rec[29:0]} modulo 2^40; a rollover emits no tag.
REQ-017 Padding emits nothing; reserved emits nothing and increments stat_reserved.
REQ-018 Handshake: a word transfers when s_axis_tvalid && s_axis_tready; tdata is captured into a 128-bit holding register.
REQ-019 FSM IDLE -> DRAIN on a transfer, with slot index idx <= 0.
REQ-020 In DRAIN, exactly one slot (idx) is decoded per cycle, regardless of record type.
REQ-021 DRAIN with idx < 3: idx increments.
REQ-022 DRAIN with idx == 3 and a transfer: the new word is loaded, idx <= 0, and the FSM stays in DRAIN.
REQ-023 DRAIN with idx == 3 and no transfer: the FSM returns to IDLE.
REQ-024 s_axis_tready = (state == IDLE) || (idx == 3); the output is combinational from state only, with no dependency on tvalid.
REQ-025 Sustained throughput: one word per 4 cycles with no bubble.
REQ-026 Outputs are registered: the slot decoded in cycle N appears on valid_tag/tagtime/channel/rising_edge in cycle N+1.
REQ-027 Latency: slot k of a word transferred at cycle T is output at cycle T+2+k.
REQ-028 A rollover in slot k applies to tag slots > k of the same word and to all later words.
REQ-029 A tag in the same slot as the base update cannot occur, since there is one record per slot.
REQ-030 When valid_tag = 0, tagtime/channel/rising_edge hold their previous values; downstream ignores them.
REQ-031 No output backpressure exists; the downstream consumer is always ready.
REQ-032 stat_rollovers wraps from 32'hFFFFFFFF to 0.
REQ-033 The 40-bit base wraps silently, and tagtime wraps with it.

Reset
REQ-034 On rst assertion, immediately and asynchronously: state = IDLE, idx = 0, holding register = 0, time_base = 0.
REQ-035 On rst assertion, immediately and asynchronously: valid_tag = 0, tagtime = 0, channel = 0, rising_edge = 0, stat_rollovers = 0, stat_reserved = 0.
REQ-036 Reset mid-DRAIN discards the remaining slots; no partial tag is emitted after release.
REQ-037 s_axis_tready is 1 during reset (IDLE), but transfers are ignored while rst is high.

Structure
REQ-038 Package si_tag_pkg holds: the record-type enum (PAD, TAG, ROLL, RSVD), the field bit positions, OFFSET_W/BASE_W constants, and a packed struct for the decoded tag.
REQ-039 Sub-module si_tag_decode: combinational, takes one 32-bit record and time_base, returns type, decoded tag, and the rollover increment.
REQ-040 The FSM, holding register, counters and output registers live in si_tag_unpacker.

Verification
REQ-041 Word {PAD, TAG ch3 rise off=0x10, PAD, TAG ch0 fall off=0xFFFFFF} transferred at T, base 0 -> valid_tag at T+3 with tagtime 0x10, ch 3, rise 1; valid_tag at T+5 with tagtime 0xFFFFFF, ch 0, rise 0; no other strobes.
REQ-042 Slot0 = ROLL 1, slot1 = TAG off=5 -> tagtime 0x0000000001000005 at T+3; stat_rollovers = 1.
REQ-043 tvalid held high for 3 words -> tready high at T, T+4, T+8; 12 consecutive slots decoded with no gap cycle.
REQ-044 Base = 2^40-1, then ROLL 1 followed by TAG off=7 -> tagtime = 7; the base wraps to 0.
REQ-045 70000 RSVD records -> stat_reserved = 16'hFFFF and no valid_tag ever asserted.
REQ-046 rst asserted at slot 1 of a word of four TAG records -> outputs 0 at once; after release, no tag emitted until a new transfer; tagtime restarts from base 0.
